// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state type and defaults for the sequential ALU.
package seq_alu_pkg;

  localparam int unsigned DefaultWidth = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_ASR = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StShift,
    StDone
  } state_e;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/seq_alu_shift.sv
// Iterative one-bit-per-cycle shifter: working register, step counter and
// the combinational next step so the caller can register the final value.
module seq_alu_shift
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   amount,
  output logic [WIDTH-1:0] next_work,
  output logic             next_out,
  output logic             last
);

  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   cnt_q;
  logic [2:0]       mode_q;

  always_comb begin
    next_work = work_q;
    next_out  = 1'b0;
    case (mode_q)
      OP_SHL: begin
        next_work = {work_q[WIDTH-2:0], 1'b0};
        next_out  = work_q[WIDTH-1];
      end
      OP_SHR: begin
        next_work = {1'b0, work_q[WIDTH-1:1]};
        next_out  = work_q[0];
      end
      default: begin
        next_work = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        next_out  = work_q[0];
      end
    endcase
  end

  // The step that sees a count of one is the final shift.
  assign last = (cnt_q == SHW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      cnt_q  <= '0;
      mode_q <= OP_SHL;
    end else if (load) begin
      work_q <= data;
      cnt_q  <= amount;
      mode_q <= mode;
    end else if (step) begin
      work_q <= next_work;
      cnt_q  <= cnt_q - SHW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU feeding the C/Z/N flag register with one-cycle load strobes.
// Define SEQ_ALU_OVF_EN to add the signed-overflow flag and its ld_v strobe.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             ld_c,
  output logic             ld_z,
  output logic             ld_n
`ifdef SEQ_ALU_OVF_EN
  ,
  output logic             overflow,
  output logic             ld_v
`endif
);

  state_e           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic             shift_go;
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;
  logic             sh_last;

  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] exec_res;
  logic             exec_c;
  logic             exec_ldc;
  logic             exec_v;

  assign shift_go = (state_q == StIdle) && start && is_shift_op(op) &&
                    (b[SHW-1:0] != '0);

  seq_alu_shift #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (shift_go),
    .step      (state_q == StShift),
    .mode      (op),
    .data      (a),
    .amount    (b[SHW-1:0]),
    .next_work (sh_next),
    .next_out  (sh_out),
    .last      (sh_last)
  );

  // SUB is a + ~b + 1, so carry set means no borrow.
  always_comb begin
    opb      = (op_q == OP_SUB) ? ~b_q : b_q;
    sum      = {1'b0, a_q} + {1'b0, opb} + {{WIDTH{1'b0}}, (op_q == OP_SUB)};
    exec_res = a_q;
    exec_c   = 1'b0;
    exec_ldc = 1'b0;
    exec_v   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        exec_res = sum[WIDTH-1:0];
        exec_c   = sum[WIDTH];
        exec_ldc = 1'b1;
        exec_v   = (a_q[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      default: exec_res = a_q;  // zero-amount shift passes a through
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      ld_c     <= 1'b0;
      ld_z     <= 1'b0;
      ld_n     <= 1'b0;
`ifdef SEQ_ALU_OVF_EN
      overflow <= 1'b0;
      ld_v     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      ld_c <= 1'b0;
      ld_z <= 1'b0;
      ld_n <= 1'b0;
`ifdef SEQ_ALU_OVF_EN
      ld_v <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            busy    <= 1'b1;
            state_q <= shift_go ? StShift : StExec;
          end
        end
        StExec: begin
          result   <= exec_res;
          carry    <= exec_c;
          zero     <= (exec_res == '0);
          negative <= exec_res[WIDTH-1];
          ld_c     <= exec_ldc;
          ld_z     <= 1'b1;
          ld_n     <= 1'b1;
          done     <= 1'b1;
          busy     <= 1'b0;
`ifdef SEQ_ALU_OVF_EN
          overflow <= exec_v;
          ld_v     <= exec_ldc;
`endif
          state_q  <= StDone;
        end
        StShift: begin
          if (sh_last) begin
            result   <= sh_next;
            carry    <= sh_out;
            zero     <= (sh_next == '0);
            negative <= sh_next[WIDTH-1];
            ld_c     <= 1'b1;
            ld_z     <= 1'b1;
            ld_n     <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
`ifdef SEQ_ALU_OVF_EN
            overflow <= 1'b0;
`endif
            state_q  <= StDone;
          end
        end
        StDone: state_q <= StIdle;
      endcase
    end
  end

endmodule
